// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column output collection FIFO below the systolic MAC array
// Columns fill independently (skewed wavefront); a row is popped from all columns at once.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_count = (aw+1)'(depth);

  logic [col-1:0] nonempty;
  logic [col-1:0] full;
  logic           pop;

  assign o_valid = &nonempty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [aw-1:0]      wptr;
    logic [aw-1:0]      rptr;
    logic [aw:0]        count;
    logic               push;

    // A full column drops the write even when the shared pop frees a slot this cycle.
    assign push        = wr[g] && (count != full_count);
    assign nonempty[g] = (count != '0);
    assign full[g]     = (count == full_count);
    assign out[g*psum_bw +: psum_bw] = mem[rptr];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < depth; i++) mem[i] <= '0;
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          mem[wptr] <= in[g*psum_bw +: psum_bw];
          wptr      <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
        count <= count + {{aw{1'b0}}, push} - {{aw{1'b0}}, pop};
      end
    end
  end

endmodule

// File: doc/ofifo.md
# ofifo

Output collection FIFO at the south edge of the systolic MAC array. Each of `col` columns has an independent `depth`-entry queue that captures the partial sum leaving the bottom `mac_tile` of that column whenever its write strobe is high. Columns finish skewed in time because the array is wavefront-driven. The block presents a row of results to the downstream SRAM write path only once every column holds at least one entry, and pops all columns together.

## Interface
- `col`, 8, number of array columns / independent queues
- `psum_bw`, 16, width of one partial sum
- `depth`, 16, entries per column queue; power of two, ≥ 2
- `clk`  input  1  system clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `in`  input  col*psum_bw  column i data on bits [psum_bw*(i+1)-1 : psum_bw*i], driven by column i bottom-tile `out_s`
- `wr`  input  col  per-column write strobe; bit i pushes column i slice of `in`
- `rd`  input  1  pop one full row from all columns
- `out`  output  col*psum_bw  head entry of each column, same bit packing as `in`
- `o_full`  output  1  high when any column queue holds `depth` entries
- `o_ready`  output  1  `~o_full`
- `o_valid`  output  1  high when every column queue holds ≥ 1 entry

## Operation
- Per column i: storage `depth` × `psum_bw`, write pointer, read pointer, occupancy count of width log2(depth)+1.
- Write: if `wr[i]` and count_i < `depth`, store the slice at wptr_i, wptr_i += 1 mod `depth`, count_i += 1.
- Write to a full column is dropped. No overwrite, pointer or count change. Dropping applies even if a pop is accepted in the same cycle.
- Read: accepted only when `rd` and `o_valid`. Every column then advances rptr_i += 1 mod `depth` and count_i -= 1.
- `rd` while `o_valid`=0 is ignored; no state changes.
- Simultaneous accepted write and accepted pop on one column: both take effect, count_i unchanged, pointers both advance.
- `out` is first-word-fall-through. Each slice is storage[rptr_i], combinationally from registered state. It is meaningful only while `o_valid`=1.
- Data is passed unmodified. No arithmetic, sign handling or width change; psum values are two's-complement as produced by the array.
- Flags are combinational from registered counts:
  - `o_full` = OR over i of (count_i == `depth`)
  - `o_valid` = AND over i of (count_i != 0)
- No state machine beyond the per-column pointer/count logic. Columns are fully independent except for the shared pop.

## Timing
- Reset applies at the first rising edge with `reset`=1 and overrides `wr` and `rd` in that cycle.
  - Clears all pointers and counts to 0 and clears storage to 0.
  - After reset: `out`=0, `o_full`=0, `o_ready`=1, `o_valid`=0.
- Reset asserted mid-operation discards all queued entries. Nothing is flushed out.
- Write-to-visible latency is 1 cycle. A push at edge N updates `o_valid`/`out` just after edge N.
- Pop takes effect at the edge. `out` shows the next row just after that edge.
- Zero-bubble streaming: `rd` held high with `o_valid`=1 pops one row per cycle.
- Pointer wrap from `depth`-1 to 0 is seamless; order is strict FIFO per column.
- `o_full` is asserted in the cycle after the `depth`-th accepted write. Upstream must stop driving `wr` for that column while `o_ready`=0, or the data is lost.

## Test plan
- Reset check: assert `reset` with `wr`=all-ones and `rd`=1 -> counts stay 0; `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1.
- Skewed fill: pulse `wr[i]` at cycle i with `in` slice i = 100+i (col=8) -> `o_valid` low through cycle 7, high after cycle 7 edge. `out` slices read 100..107. One `rd` -> `o_valid`=0.
- Fill to full: 16 writes on column 0 with values 0..15 -> `o_full`=1 and `o_ready`=0 after the 16th. A 17th write with value 99 is dropped.
  - Then fill the other columns and pop 16 times -> column 0 reads 0..15 in order, never 99.
- Wrap-around: 40 rows streamed with `wr`=all-ones, value = row index, and `rd` high from the second cycle -> rows emerge in order 0..39, count ≤ 2, no `o_full`.
- Ignored read / same-cycle read-write:
  - `rd`=1 while column 3 is empty -> no pointer movement in other columns.
  - At count=1 with `wr`=all-ones and `rd`=1 -> count stays 1 and `out` shows the new row next cycle.
- Mid-operation reset: 5 rows queued, then `reset` for one cycle -> `o_valid`=0 and `out`=0. A subsequent single row of 7s reads back as 7s.
